// File: rtl/multicycle_controller_if.sv
// Control and handshake bundle between the multicycle controller and the datapath/memories.
// Latency: none, wires only; master = controller side, slave = datapath side.
// Backpressure: memory readiness flows in on imem_ready/dmem_ready; requests stay high until ready.
interface multicycle_controller_if;
    // decoder and memory status into the controller
    logic [5:0] opcode;
    logic       ins_zero;
    logic       alu_zero;
    logic       imem_ready;
    logic       dmem_ready;

    // datapath enables and muxes out of the controller
    logic       imem_req;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic [3:0] alu_op;
    logic       alu_src_imm;
    logic       dmem_req;
    logic       dmem_we;
    logic       reg_write;
    logic       mem_to_reg;
    logic       halted;
    logic       illegal;
    logic       bus_error;
    logic [2:0] state;

    modport master (
        input  opcode, ins_zero, alu_zero, imem_ready, dmem_ready,
        output imem_req, ir_write, pc_write, pc_src, alu_op, alu_src_imm,
               dmem_req, dmem_we, reg_write, mem_to_reg,
               halted, illegal, bus_error, state
    );

    modport slave (
        output opcode, ins_zero, alu_zero, imem_ready, dmem_ready,
        input  imem_req, ir_write, pc_write, pc_src, alu_op, alu_src_imm,
               dmem_req, dmem_we, reg_write, mem_to_reg,
               halted, illegal, bus_error, state
    );
endinterface

// File: rtl/multicycle_controller.sv
// Multi-cycle control FSM: fetch, decode, execute, memory and writeback sequencing for the core.
// Latency: 2 (NOP) to 5 (LW) cycles per instruction with zero-wait memories.
// Backpressure: FETCH/MEM hold their request until ready; WAIT_LIMIT unanswered cycles halt with bus_error.
module multicycle_controller #(
    parameter int WAIT_LIMIT = 15,   // must be >= 1
    parameter int CNT_W      = 4     // must satisfy 2**CNT_W > WAIT_LIMIT
) (
    input  logic                    clk,
    input  logic                    rst,
    multicycle_controller_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd7
    } state_t;

    typedef enum logic [2:0] {
        C_RTYPE,
        C_ITYPE,
        C_LW,
        C_SW,
        C_BEQ,
        C_BNE,
        C_ILL
    } op_class_t;

    // Instruction class of a 6-bit opcode; NOP is handled separately via ins_zero.
    function automatic op_class_t classify(input logic [5:0] op);
        op_class_t c;
        casez (op)
            6'b00????: c = C_RTYPE;
            6'b010???: c = C_ITYPE;
            6'b011000: c = C_LW;
            6'b011001: c = C_SW;
            6'b011010: c = C_BEQ;
            6'b011011: c = C_BNE;
            default:   c = C_ILL;
        endcase
        return c;
    endfunction

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   wait_cnt;
    logic [5:0]         opcode_q;
    logic               halt_illegal;
    logic               halt_bus;
    logic               waiting;
    logic               at_limit;
    op_class_t          live_cls;
    op_class_t          exec_cls;

    logic               halted_q;
    logic               illegal_q;
    logic               bus_error_q;

    logic               imem_req_c;
    logic               ir_write_c;
    logic               pc_write_c;
    logic [1:0]         pc_src_c;
    logic [3:0]         alu_op_c;
    logic               alu_src_imm_c;
    logic               dmem_req_c;
    logic               dmem_we_c;
    logic               reg_write_c;
    logic               mem_to_reg_c;
    logic [3:0]         alu_op_dec;
    logic               alu_src_dec;

    // DECODE looks at the live opcode; everything after uses the copy captured at the end of DECODE.
    assign live_cls = classify(bus.opcode);
    assign exec_cls = classify(opcode_q);

    // A request is waiting when it is out and its memory has not answered this cycle.
    assign waiting  = ((state_q == S_FETCH) && !bus.imem_ready) ||
                      ((state_q == S_MEM)   && !bus.dmem_ready);
    assign at_limit = (wait_cnt == CNT_W'(WAIT_LIMIT));

    // State register, wait counter (cleared on any state change) and opcode capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            wait_cnt <= '0;
            opcode_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_d != state_q) begin
                wait_cnt <= '0;
            end else if (waiting) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end
            if (state_q == S_DECODE) begin
                opcode_q <= bus.opcode;
            end
        end
    end

    // Sticky halt flags, set on the edge that enters HALT and held until reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            halted_q    <= 1'b0;
            illegal_q   <= 1'b0;
            bus_error_q <= 1'b0;
        end else if (halt_illegal || halt_bus) begin
            halted_q    <= 1'b1;
            illegal_q   <= halt_illegal;
            bus_error_q <= halt_bus;
        end
    end

    // Next-state logic; a ready arriving on the limit cycle wins over the timeout.
    always_comb begin
        state_d      = state_q;
        halt_illegal = 1'b0;
        halt_bus     = 1'b0;
        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                if (bus.imem_ready) begin
                    state_d = S_DECODE;
                end else if (at_limit) begin
                    state_d  = S_HALT;
                    halt_bus = 1'b1;
                end
            end
            S_DECODE: begin
                if (bus.ins_zero) begin
                    state_d = S_FETCH;
                end else if (live_cls == C_ILL) begin
                    state_d      = S_HALT;
                    halt_illegal = 1'b1;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                case (exec_cls)
                    C_RTYPE, C_ITYPE: state_d = S_WB;
                    C_LW, C_SW:       state_d = S_MEM;
                    default:          state_d = S_FETCH;
                endcase
            end
            S_MEM: begin
                if (bus.dmem_ready) begin
                    state_d = (exec_cls == C_SW) ? S_FETCH : S_WB;
                end else if (at_limit) begin
                    state_d  = S_HALT;
                    halt_bus = 1'b1;
                end
            end
            S_WB: begin
                state_d = S_FETCH;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ALU function and operand-B select for the captured instruction.
    always_comb begin
        alu_op_dec  = 4'd0;
        alu_src_dec = 1'b0;
        case (exec_cls)
            C_RTYPE: begin
                alu_op_dec  = opcode_q[3:0];
            end
            C_ITYPE: begin
                alu_op_dec  = opcode_q[3:0];
                alu_src_dec = 1'b1;
            end
            C_LW, C_SW: begin
                alu_op_dec  = 4'b0000;
                alu_src_dec = 1'b1;
            end
            C_BEQ, C_BNE: begin
                alu_op_dec  = 4'b0001;
            end
            default: begin
                alu_op_dec  = 4'd0;
            end
        endcase
    end

    // Datapath controls: requests/writeback from state, IR/PC writes gated by ready or branch outcome.
    always_comb begin
        imem_req_c    = 1'b0;
        ir_write_c    = 1'b0;
        pc_write_c    = 1'b0;
        pc_src_c      = 2'b00;
        alu_op_c      = 4'd0;
        alu_src_imm_c = 1'b0;
        dmem_req_c    = 1'b0;
        dmem_we_c     = 1'b0;
        reg_write_c   = 1'b0;
        mem_to_reg_c  = 1'b0;
        case (state_q)
            S_FETCH: begin
                imem_req_c = 1'b1;
                if (bus.imem_ready) begin
                    ir_write_c = 1'b1;
                    pc_write_c = 1'b1;
                    pc_src_c   = 2'b00;
                end
            end
            S_EXEC: begin
                alu_op_c      = alu_op_dec;
                alu_src_imm_c = alu_src_dec;
                if (((exec_cls == C_BEQ) &&  bus.alu_zero) ||
                    ((exec_cls == C_BNE) && !bus.alu_zero)) begin
                    pc_write_c = 1'b1;
                    pc_src_c   = 2'b01;
                end
            end
            S_MEM: begin
                alu_op_c      = alu_op_dec;
                alu_src_imm_c = alu_src_dec;
                dmem_req_c    = 1'b1;
                dmem_we_c     = (exec_cls == C_SW);
            end
            S_WB: begin
                alu_op_c      = alu_op_dec;
                alu_src_imm_c = alu_src_dec;
                reg_write_c   = 1'b1;
                mem_to_reg_c  = (exec_cls == C_LW);
            end
            default: begin
                imem_req_c = 1'b0;
            end
        endcase
    end

    assign bus.imem_req    = imem_req_c;
    assign bus.ir_write    = ir_write_c;
    assign bus.pc_write    = pc_write_c;
    assign bus.pc_src      = pc_src_c;
    assign bus.alu_op      = alu_op_c;
    assign bus.alu_src_imm = alu_src_imm_c;
    assign bus.dmem_req    = dmem_req_c;
    assign bus.dmem_we     = dmem_we_c;
    assign bus.reg_write   = reg_write_c;
    assign bus.mem_to_reg  = mem_to_reg_c;
    assign bus.halted      = halted_q;
    assign bus.illegal     = illegal_q;
    assign bus.bus_error   = bus_error_q;
    assign bus.state       = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: per-instruction state walks, halts and async reset.
// Latency: inputs driven 1 time unit after the rising edge, outputs sampled on the falling edge.
// Backpressure: memory ready lines are held low for scripted cycle counts to exercise waits and timeouts.
module tb_multicycle_controller;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    multicycle_controller_if bus();

    multicycle_controller #(.WAIT_LIMIT(15), .CNT_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    logic [19:0] outs;
    assign outs = {bus.imem_req, bus.ir_write, bus.pc_write, bus.pc_src, bus.alu_op,
                   bus.alu_src_imm, bus.dmem_req, bus.dmem_we, bus.reg_write,
                   bus.mem_to_reg, bus.halted, bus.illegal, bus.bus_error, bus.state};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the DUT in FETCH at 1 time unit after the edge, all inputs low.
    task automatic do_reset();
        rst            = 1'b1;
        bus.opcode     = 6'd0;
        bus.ins_zero   = 1'b0;
        bus.alu_zero   = 1'b0;
        bus.imem_ready = 1'b0;
        bus.dmem_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        bus.opcode = 6'd0; bus.ins_zero = 1'b0; bus.alu_zero = 1'b0;
        bus.imem_ready = 1'b0; bus.dmem_ready = 1'b0;
        rst = 1'b0;
        #1 rst = 1'b1;
        #1;
        checks++; if (outs !== 20'd0) begin errors++; $display("FAIL reset_outs got=%h exp=0", outs); end
        tick(); tick();
        rst = 1'b0;
        @(negedge clk);
        checks++; if (outs !== 20'd0) begin errors++; $display("FAIL reset_idle got=%h exp=0", outs); end
        tick();
        @(negedge clk);
        checks++; if ({bus.imem_req, bus.ir_write, bus.pc_write, bus.state} !== 6'b100001)
            begin errors++; $display("FAIL reset_fetch got=%b exp=100001", {bus.imem_req, bus.ir_write, bus.pc_write, bus.state}); end
    endtask

    task automatic test_rtype();
        do_reset();
        bus.opcode = 6'b000011; bus.imem_ready = 1'b1;
        @(negedge clk);
        checks++; if ({bus.imem_req, bus.ir_write, bus.pc_write, bus.pc_src, bus.state} !== 8'b1110_0001)
            begin errors++; $display("FAIL rtype_fetch got=%b exp=11100001", {bus.imem_req, bus.ir_write, bus.pc_write, bus.pc_src, bus.state}); end
        tick(); @(negedge clk);
        checks++; if ({bus.state, bus.imem_req, bus.ir_write, bus.pc_write, bus.dmem_req, bus.reg_write} !== 8'b010_00000)
            begin errors++; $display("FAIL rtype_decode got=%b exp=01000000", {bus.state, bus.imem_req, bus.ir_write, bus.pc_write, bus.dmem_req, bus.reg_write}); end
        tick();
        bus.opcode = 6'b111111;
        @(negedge clk);
        checks++; if ({bus.state, bus.alu_op, bus.alu_src_imm, bus.reg_write} !== 9'b011_0011_0_0)
            begin errors++; $display("FAIL rtype_exec got=%b exp=011001100", {bus.state, bus.alu_op, bus.alu_src_imm, bus.reg_write}); end
        tick(); @(negedge clk);
        checks++; if ({bus.state, bus.reg_write, bus.mem_to_reg, bus.alu_op} !== 9'b101_1_0_0011)
            begin errors++; $display("FAIL rtype_wb got=%b exp=101100011", {bus.state, bus.reg_write, bus.mem_to_reg, bus.alu_op}); end
        tick(); @(negedge clk);
        checks++; if ({bus.state, bus.reg_write} !== 4'b001_0)
            begin errors++; $display("FAIL rtype_refetch got=%b exp=0010", {bus.state, bus.reg_write}); end
    endtask

    task automatic test_lw_wait();
        do_reset();
        bus.opcode = 6'b011000; bus.imem_ready = 1'b1;
        tick(); tick();
        @(negedge clk);
        checks++; if ({bus.state, bus.alu_op, bus.alu_src_imm} !== 8'b011_0000_1)
            begin errors++; $display("FAIL lw_exec got=%b exp=01100001", {bus.state, bus.alu_op, bus.alu_src_imm}); end
        tick();
        for (int i = 0; i < 4; i++) begin
            bus.dmem_ready = (i == 3);
            @(negedge clk);
            checks++; if ({bus.state, bus.dmem_req, bus.dmem_we} !== 5'b100_1_0)
                begin errors++; $display("FAIL lw_mem%0d got=%b exp=10010", i, {bus.state, bus.dmem_req, bus.dmem_we}); end
            tick();
        end
        bus.dmem_ready = 1'b0;
        @(negedge clk);
        checks++; if ({bus.state, bus.mem_to_reg, bus.reg_write, bus.dmem_req} !== 6'b101_1_1_0)
            begin errors++; $display("FAIL lw_wb got=%b exp=101110", {bus.state, bus.mem_to_reg, bus.reg_write, bus.dmem_req}); end
        tick(); @(negedge clk);
        checks++; if (bus.state !== 3'd1) begin errors++; $display("FAIL lw_refetch got=%0d exp=1", bus.state); end
    endtask

    task automatic test_sw();
        do_reset();
        bus.opcode = 6'b011001; bus.imem_ready = 1'b1; bus.dmem_ready = 1'b1;
        tick(); tick(); tick();
        @(negedge clk);
        checks++; if ({bus.state, bus.dmem_req, bus.dmem_we, bus.alu_src_imm, bus.reg_write} !== 7'b100_1_1_1_0)
            begin errors++; $display("FAIL sw_mem got=%b exp=1001110", {bus.state, bus.dmem_req, bus.dmem_we, bus.alu_src_imm, bus.reg_write}); end
        tick(); @(negedge clk);
        checks++; if ({bus.state, bus.dmem_req, bus.reg_write} !== 5'b001_0_0)
            begin errors++; $display("FAIL sw_refetch got=%b exp=00100", {bus.state, bus.dmem_req, bus.reg_write}); end
    endtask

    task automatic test_branch();
        do_reset();
        bus.opcode = 6'b011010; bus.imem_ready = 1'b1;
        tick(); tick();
        bus.alu_zero = 1'b1;
        @(negedge clk);
        checks++; if ({bus.state, bus.pc_write, bus.pc_src, bus.alu_op, bus.alu_src_imm, bus.ir_write} !== 12'b011_1_01_0001_0_0)
            begin errors++; $display("FAIL beq_taken got=%b exp=011101000100", {bus.state, bus.pc_write, bus.pc_src, bus.alu_op, bus.alu_src_imm, bus.ir_write}); end
        tick(); @(negedge clk);
        checks++; if (bus.state !== 3'd1) begin errors++; $display("FAIL beq_refetch got=%0d exp=1", bus.state); end
        bus.opcode = 6'b011011;
        tick(); tick();
        @(negedge clk);
        checks++; if ({bus.state, bus.pc_write} !== 4'b011_0)
            begin errors++; $display("FAIL bne_not_taken got=%b exp=0110", {bus.state, bus.pc_write}); end
        tick(); @(negedge clk);
        checks++; if (bus.state !== 3'd1) begin errors++; $display("FAIL bne_refetch got=%0d exp=1", bus.state); end
        tick(); tick();
        bus.alu_zero = 1'b0;
        @(negedge clk);
        checks++; if ({bus.state, bus.pc_write, bus.pc_src} !== 6'b011_1_01)
            begin errors++; $display("FAIL bne_taken got=%b exp=011101", {bus.state, bus.pc_write, bus.pc_src}); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        bus.opcode = 6'd0; bus.ins_zero = 1'b1; bus.imem_ready = 1'b1;
        tick(); @(negedge clk);
        checks++; if (bus.state !== 3'd2) begin errors++; $display("FAIL nop_decode got=%0d exp=2", bus.state); end
        tick(); @(negedge clk);
        checks++; if ({bus.state, bus.ir_write} !== 4'b001_1)
            begin errors++; $display("FAIL nop_refetch got=%b exp=0011", {bus.state, bus.ir_write}); end
        bus.ins_zero = 1'b0; bus.opcode = 6'b010101;
        tick(); tick();
        @(negedge clk);
        checks++; if ({bus.state, bus.alu_op, bus.alu_src_imm} !== 8'b011_0101_1)
            begin errors++; $display("FAIL itype_exec got=%b exp=01101011", {bus.state, bus.alu_op, bus.alu_src_imm}); end
        tick(); @(negedge clk);
        checks++; if ({bus.state, bus.reg_write, bus.mem_to_reg} !== 5'b101_1_0)
            begin errors++; $display("FAIL itype_wb got=%b exp=10110", {bus.state, bus.reg_write, bus.mem_to_reg}); end
    endtask

    task automatic test_illegal();
        do_reset();
        bus.opcode = 6'b111111; bus.imem_ready = 1'b1;
        tick(); @(negedge clk);
        checks++; if ({bus.state, bus.halted} !== 4'b010_0)
            begin errors++; $display("FAIL ill_decode got=%b exp=0100", {bus.state, bus.halted}); end
        tick(); @(negedge clk);
        checks++; if ({bus.state, bus.halted, bus.illegal, bus.bus_error, bus.imem_req} !== 7'b111_1_1_0_0)
            begin errors++; $display("FAIL ill_halt got=%b exp=1111100", {bus.state, bus.halted, bus.illegal, bus.bus_error, bus.imem_req}); end
        for (int i = 0; i < 4; i++) begin
            tick(); @(negedge clk);
            checks++; if ({bus.state, bus.imem_req, bus.ir_write, bus.pc_write, bus.halted} !== 7'b111_0_0_0_1)
                begin errors++; $display("FAIL ill_hold%0d got=%b exp=1110001", i, {bus.state, bus.imem_req, bus.ir_write, bus.pc_write, bus.halted}); end
        end
    endtask

    task automatic test_timeout();
        do_reset();
        bus.opcode = 6'b000001;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            checks++; if ({bus.state, bus.imem_req} !== 4'b001_1)
                begin errors++; $display("FAIL fetch_wait%0d got=%b exp=0011", i, {bus.state, bus.imem_req}); end
            tick();
        end
        @(negedge clk);
        checks++; if ({bus.state, bus.halted, bus.illegal, bus.bus_error, bus.imem_req} !== 7'b111_1_0_1_0)
            begin errors++; $display("FAIL fetch_timeout got=%b exp=1111010", {bus.state, bus.halted, bus.illegal, bus.bus_error, bus.imem_req}); end

        do_reset();
        bus.opcode = 6'b000001;
        for (int i = 0; i < 15; i++) tick();
        bus.imem_ready = 1'b1;
        @(negedge clk);
        checks++; if ({bus.state, bus.ir_write} !== 4'b001_1)
            begin errors++; $display("FAIL limit_ready got=%b exp=0011", {bus.state, bus.ir_write}); end
        tick(); @(negedge clk);
        checks++; if ({bus.state, bus.halted, bus.bus_error} !== 5'b010_0_0)
            begin errors++; $display("FAIL limit_decode got=%b exp=01000", {bus.state, bus.halted, bus.bus_error}); end

        do_reset();
        bus.opcode = 6'b011000; bus.imem_ready = 1'b1;
        tick(); tick(); tick();
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            checks++; if (bus.state !== 3'd4) begin errors++; $display("FAIL mem_wait%0d got=%0d exp=4", i, bus.state); end
            tick();
        end
        @(negedge clk);
        checks++; if ({bus.state, bus.bus_error, bus.illegal, bus.dmem_req} !== 6'b111_1_0_0)
            begin errors++; $display("FAIL mem_timeout got=%b exp=111100", {bus.state, bus.bus_error, bus.illegal, bus.dmem_req}); end
    endtask

    task automatic test_async_reset();
        do_reset();
        bus.opcode = 6'b011000; bus.imem_ready = 1'b1;
        tick(); tick(); tick();
        #1;
        checks++; if ({bus.state, bus.dmem_req} !== 4'b100_1)
            begin errors++; $display("FAIL mid_mem got=%b exp=1001", {bus.state, bus.dmem_req}); end
        #1 rst = 1'b1;
        #1;
        checks++; if (outs !== 20'd0) begin errors++; $display("FAIL async_clear got=%h exp=0", outs); end
        tick();
        rst = 1'b0;
        @(negedge clk);
        checks++; if (outs !== 20'd0) begin errors++; $display("FAIL post_rst_idle got=%h exp=0", outs); end
        tick(); @(negedge clk);
        checks++; if ({bus.state, bus.imem_req} !== 4'b001_1)
            begin errors++; $display("FAIL post_rst_fetch got=%b exp=0011", {bus.state, bus.imem_req}); end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_lw_wait();
        test_sw();
        test_branch();
        test_back_to_back();
        test_illegal();
        test_timeout();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
